// File: rtl/sub16_pkg.sv
// -----------------------------------------------------------------------------
// sub16_pkg
// Shared definitions for the digit-serial 16-bit subtractor sub16_seq.
//   WIDTH      : operand / result width (16)
//   state_t    : controller states IDLE, RUN, DONE
//   num_digits : number of digit steps N for a given digit width
// No ports (package).
// -----------------------------------------------------------------------------
package sub16_pkg;

   localparam int WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Guarded against a zero width so an illegal DIGIT_W reaches the
   // elaboration check in the top instead of a divide-by-zero.
   function automatic int num_digits(input int digit_w);
      if (digit_w > 0) return WIDTH / digit_w;
      else             return 1;
   endfunction

endpackage

// File: rtl/sub16_seq_if.sv
// -----------------------------------------------------------------------------
// sub16_seq_if
// Request/result bundle of sub16_seq.
//   start, a, b, bin          : request (master -> slave)
//   busy, done, d, bout, zero : status and result (slave -> master)
//   ovf                       : signed overflow, present only when
//                               SUB16_OVF_EN is defined
// Modports: master (requester side), slave (sub16_seq side).
// -----------------------------------------------------------------------------
interface sub16_seq_if;
   import sub16_pkg::*;

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             zero;
`ifdef SUB16_OVF_EN
   logic             ovf;

   modport master (output start, a, b, bin,
                   input  busy, done, d, bout, zero, ovf);
   modport slave  (input  start, a, b, bin,
                   output busy, done, d, bout, zero, ovf);
`else
   modport master (output start, a, b, bin,
                   input  busy, done, d, bout, zero);
   modport slave  (input  start, a, b, bin,
                   output busy, done, d, bout, zero);
`endif

endinterface

// File: rtl/sub16_seq_sub_digit.sv
// -----------------------------------------------------------------------------
// sub_digit
// Combinational one-digit subtractor: diff = x - y - bin (mod 2^DIGIT_W),
// bout set when x < y + bin (unsigned).
//   x, y : DIGIT_W-bit operand digits
//   bin  : borrow in
//   diff : DIGIT_W-bit difference digit
//   bout : borrow out
// -----------------------------------------------------------------------------
module sub_digit #(
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               bin,
   output logic [DIGIT_W-1:0] diff,
   output logic               bout
);

   // One extra bit catches the borrow: a negative result wraps and sets it.
   logic [DIGIT_W:0] w_full;

   assign w_full = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};
   assign diff   = w_full[DIGIT_W-1:0];
   assign bout   = w_full[DIGIT_W];

endmodule

// File: rtl/sub16_seq.sv
// -----------------------------------------------------------------------------
// sub16_seq
// Digit-serial 16-bit subtractor d = a - b - bin. One DIGIT_W-bit digit is
// processed per cycle, least-significant first, through a single shared
// sub_digit instance. Latency from accepted start to done is N+1 cycles,
// N = 16/DIGIT_W.
// Optional feature: define SUB16_OVF_EN to add the signed-overflow output ovf.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sub16_seq_if.slave (start, a, b, bin in; busy, done, d, bout,
//         zero [, ovf] out)
// -----------------------------------------------------------------------------
module sub16_seq
   import sub16_pkg::*;
#(
   parameter int DIGIT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   sub16_seq_if.slave bus
);

   localparam int N   = num_digits(DIGIT_W);
   localparam int K_W = (N > 1) ? $clog2(N) : 1;

   generate
      if ((DIGIT_W < 1) || (DIGIT_W > WIDTH) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_digit_w
         $error("sub16_seq: DIGIT_W=%0d does not divide %0d", DIGIT_W, WIDTH);
      end
   endgenerate

   state_t                   r_state;
   logic [K_W-1:0]           r_k;
   logic [WIDTH-1:0]         r_a;
   logic [WIDTH-1:0]         r_b;
   logic [WIDTH-1:0]         r_acc;
   logic                     r_borrow;

   logic                     w_accept;
   logic                     w_last;
   logic [3:0]               w_base;
   logic [WIDTH-1:0]         w_a_sh;
   logic [WIDTH-1:0]         w_b_sh;
   logic [DIGIT_W-1:0]       w_x;
   logic [DIGIT_W-1:0]       w_y;
   logic [DIGIT_W-1:0]       w_diff;
   logic                     w_bout;
   logic [WIDTH+DIGIT_W-1:0] w_cat;
   logic [WIDTH+DIGIT_W-1:0] w_shift;
   logic [WIDTH-1:0]         w_d_next;
`ifdef SUB16_OVF_EN
   logic                     w_ovf_next;
`endif

   // start is only honoured outside RUN; DONE accepts for back-to-back use.
   assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_k == K_W'(N - 1));

   // Digit k of each operand is brought down to bit 0 by a variable shift.
   // k*DIGIT_W never exceeds 15; for DIGIT_W=16 k is always 0.
   assign w_base = 4'(r_k) * 4'(DIGIT_W);
   assign w_a_sh = r_a >> w_base;
   assign w_b_sh = r_b >> w_base;
   assign w_x    = w_a_sh[DIGIT_W-1:0];
   assign w_y    = w_b_sh[DIGIT_W-1:0];

   sub_digit #(
      .DIGIT_W (DIGIT_W)
   ) u_digit (
      .x    (w_x),
      .y    (w_y),
      .bin  (r_borrow),
      .diff (w_diff),
      .bout (w_bout)
   );

   // The accumulator shifts right, new digit entering at the top; after N
   // steps the first digit has reached bit 0. On the last step w_d_next is
   // the complete difference.
   assign w_cat    = {w_diff, r_acc};
   assign w_shift  = w_cat >> DIGIT_W;
   assign w_d_next = w_shift[WIDTH-1:0];

`ifdef SUB16_OVF_EN
   assign w_ovf_next = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_d_next[WIDTH-1] != r_a[WIDTH-1]);
`endif

   // Operand / partial-result registers: contents are don't-care until a
   // start is accepted, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a      <= bus.a;
         r_b      <= bus.b;
         r_borrow <= bus.bin;
         r_acc    <= '0;
      end else if (r_state == RUN) begin
         r_acc    <= w_d_next;
         r_borrow <= w_bout;
      end
   end

   // Controller with registered status and result outputs. Results are
   // written only on the final digit, so partial values never show.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_k       <= '0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.d     <= '0;
         bus.bout  <= 1'b0;
         bus.zero  <= 1'b0;
`ifdef SUB16_OVF_EN
         bus.ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  r_state  <= RUN;
                  r_k      <= '0;
                  bus.busy <= 1'b1;
               end
            end
            RUN: begin
               if (w_last) begin
                  r_state  <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.d    <= w_d_next;
                  bus.bout <= w_bout;
                  bus.zero <= (w_d_next == '0);
`ifdef SUB16_OVF_EN
                  bus.ovf  <= w_ovf_next;
`endif
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  r_state  <= RUN;
                  r_k      <= '0;
                  bus.busy <= 1'b1;
               end else begin
                  r_state  <= IDLE;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_k      <= '0;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub16_seq.sv
// -----------------------------------------------------------------------------
// tb_sub16_seq
// Bench for sub16_seq: three instances (DIGIT_W = 4, 1, 16) share operands
// and reset, each with its own start, and are compared every cycle against
// a plain-arithmetic reference. Define SUB16_OVF_EN to include ovf.
// -----------------------------------------------------------------------------
module tb_sub16_seq;
   import sub16_pkg::*;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      logic        z;
      logic        ov;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  st;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_bin;

   always #5 clk = ~clk;

   sub16_seq_if if4 ();
   sub16_seq_if if1 ();
   sub16_seq_if if16 ();

   assign if4.start  = st[0];
   assign if1.start  = st[1];
   assign if16.start = st[2];
   assign if4.a  = op_a;  assign if4.b  = op_b;  assign if4.bin  = op_bin;
   assign if1.a  = op_a;  assign if1.b  = op_b;  assign if1.bin  = op_bin;
   assign if16.a = op_a;  assign if16.b = op_b;  assign if16.bin = op_bin;

   sub16_seq #(.DIGIT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
   sub16_seq #(.DIGIT_W(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
   sub16_seq #(.DIGIT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

   logic        busy_w [3];
   logic        done_w [3];
   logic [15:0] d_w    [3];
   logic        bout_w [3];
   logic        zero_w [3];
   assign busy_w[0] = if4.busy;  assign busy_w[1] = if1.busy;  assign busy_w[2] = if16.busy;
   assign done_w[0] = if4.done;  assign done_w[1] = if1.done;  assign done_w[2] = if16.done;
   assign d_w[0]    = if4.d;     assign d_w[1]    = if1.d;     assign d_w[2]    = if16.d;
   assign bout_w[0] = if4.bout;  assign bout_w[1] = if1.bout;  assign bout_w[2] = if16.bout;
   assign zero_w[0] = if4.zero;  assign zero_w[1] = if1.zero;  assign zero_w[2] = if16.zero;
`ifdef SUB16_OVF_EN
   logic        ovf_w  [3];
   assign ovf_w[0]  = if4.ovf;   assign ovf_w[1]  = if1.ovf;   assign ovf_w[2]  = if16.ovf;
`endif

   int   lat [3] = '{5, 17, 2};
   res_t exp_r [3];
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference: unsigned and signed integer arithmetic on the operand values.
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
      res_t r;
      int   du;
      int   ds;
      du   = int'(a) - int'(b) - int'(bi);
      ds   = int'($signed(a)) - int'($signed(b)) - int'(bi);
      r.d  = du[15:0];
      r.bo = (du < 0);
      r.z  = (r.d == 16'h0000);
      r.ov = (ds > 32767) || (ds < -32768);
      return r;
   endfunction

   task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
      end
   endtask

   task automatic chk_dut(input int i, input logic eb, input logic ed);
      chk("busy", i, {15'd0, busy_w[i]}, {15'd0, eb});
      chk("done", i, {15'd0, done_w[i]}, {15'd0, ed});
      chk("d",    i, d_w[i], exp_r[i].d);
      chk("bout", i, {15'd0, bout_w[i]}, {15'd0, exp_r[i].bo});
      chk("zero", i, {15'd0, zero_w[i]}, {15'd0, exp_r[i].z});
`ifdef SUB16_OVF_EN
      chk("ovf",  i, {15'd0, ovf_w[i]}, {15'd0, exp_r[i].ov});
`endif
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 3; i++) begin
         exp_r[i].d  = 16'h0000;
         exp_r[i].bo = 1'b0;
         exp_r[i].z  = 1'b0;
         exp_r[i].ov = 1'b0;
      end
   endtask

   // One operation on the DUTs selected by m; optionally re-pulse start with
   // fresh operands in cycle poke_cyc (only where that DUT is still in RUN).
   task automatic run_op(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input int poke_cyc);
      res_t r;
      logic eb;
      logic ed;
      r = model(a, b, bi);
      @(negedge clk);
      op_a = a; op_b = b; op_bin = bi; st = m;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         st = 3'b000;
         for (int i = 0; i < 3; i++) begin
            eb = m[i] && (cyc < lat[i]);
            ed = m[i] && (cyc == lat[i]);
            if (ed) exp_r[i] = r;
            chk_dut(i, eb, ed);
         end
         if (cyc == poke_cyc) begin
            op_a = 16'($urandom); op_b = 16'($urandom); op_bin = 1'($urandom); st = m;
         end
      end
   endtask

   logic [15:0] da   [6] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF};
   logic [15:0] db   [6] = '{16'h0234, 16'h0001, 16'h0004, 16'h0001, 16'hFFFF, 16'hFFFF};
   logic        dbin [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      res_t r1;
      res_t r2;
      logic eb;
      logic ed;

      // Reset with start asserted: reset must win.
      rst = 1'b1; st = 3'b111; op_a = 16'h1111; op_b = 16'h2222; op_bin = 1'b0;
      clear_exp();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) chk_dut(i, 1'b0, 1'b0);
      rst = 1'b0; st = 3'b000;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_dut(i, 1'b0, 1'b0);

      // Directed vectors on all three widths.
      for (int t = 0; t < 6; t++) run_op(3'b111, da[t], db[t], dbin[t], 0);

      // Randomized vectors.
      repeat (12) run_op(3'b111, 16'($urandom), 16'($urandom), 1'($urandom), 0);

      // start re-pulsed during RUN with other operands is ignored.
      run_op(3'b011, 16'hA5A5, 16'h1234, 1'b0, 2);

      // start held high through DONE: second op accepted in the DONE cycle.
      r1 = model(16'h4321, 16'h1111, 1'b1);
      r2 = model(16'h0010, 16'h0020, 1'b0);
      @(negedge clk);
      op_a = 16'h4321; op_b = 16'h1111; op_bin = 1'b1; st = 3'b001;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(negedge clk);
         eb = ((cyc >= 1) && (cyc <= 4)) || ((cyc >= 6) && (cyc <= 9));
         ed = (cyc == 5) || (cyc == 10);
         if (cyc == 5)  exp_r[0] = r1;
         if (cyc == 10) exp_r[0] = r2;
         chk_dut(0, eb, ed);
         chk_dut(1, 1'b0, 1'b0);
         chk_dut(2, 1'b0, 1'b0);
         if (cyc == 1) begin op_a = 16'h0010; op_b = 16'h0020; op_bin = 1'b0; end
         if (cyc == 6) st = 3'b000;
      end

      // Reset in cycle 3 of RUN: operation abandoned, no done afterwards.
      @(negedge clk);
      op_a = 16'h9999; op_b = 16'h0001; op_bin = 1'b0; st = 3'b001;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         st = 3'b000;
         if (cyc == 4) begin
            clear_exp();
            rst = 1'b0;
         end
         for (int i = 0; i < 3; i++) chk_dut(i, (i == 0) && (cyc <= 3), 1'b0);
         if (cyc == 3) rst = 1'b1;
      end

      // Normal operation resumes after the abort.
      run_op(3'b111, 16'h1234, 16'h0234, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
